// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - Wishbone/LA round-robin arbiter and sequencer for a single-port SRAM macro (LA port gated by SRAM_ARB_LA_PORT_EN)

module sram_port_arbiter #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              la_req_i,
    input  logic              la_we_i,
    input  logic [ADDR_W-1:0] la_addr_i,
    input  logic [31:0]       la_wdata_i,
    output logic              la_ack_o,
    output logic [31:0]       la_rdata_o,
    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [3:0]        sram_wmask_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_din_o,
    input  logic [31:0]       sram_dout_i
);

`ifdef SRAM_ARB_LA_PORT_EN
    localparam logic LA_EN = 1'b1;
`else
    localparam logic LA_EN = 1'b0;
`endif

    localparam logic GNT_WB = 1'b0;
    localparam logic GNT_LA = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic              abort_q, abort_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              wbs_ack_q, wbs_ack_d;
    logic              la_ack_q, la_ack_d;
    logic [31:0]       wbs_dat_q, wbs_dat_d;
    logic [31:0]       la_rdata_q, la_rdata_d;

    logic wb_req, la_req, wb_in_win, pick_la;
    logic unused_adr_bits;

    // The ~ack terms stop a requester that is still asserting in its ack cycle from being granted twice.
    assign wb_req          = wbs_cyc_i & wbs_stb_i & ~wbs_ack_q;
    assign la_req          = LA_EN & la_req_i & ~la_ack_q;
    assign wb_in_win       = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    // Next-state, arbitration and SRAM pin sequencing.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        abort_d      = abort_q;
        csb_d        = 1'b1;
        web_d        = 1'b1;
        wmask_d      = 4'h0;
        addr_d       = addr_q;
        din_d        = din_q;
        wbs_ack_d    = 1'b0;
        la_ack_d     = 1'b0;
        wbs_dat_d    = wbs_dat_q;
        la_rdata_d   = la_rdata_q;
        pick_la      = la_req & (~wb_req | (last_grant_q == GNT_WB));

        // A Wishbone master that drops cyc/stb mid-access loses its ack, but the SRAM access finishes.
        if (state_q != IDLE && grant_q == GNT_WB && !(wbs_cyc_i && wbs_stb_i)) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (wb_req || la_req) begin
                    grant_d = pick_la ? GNT_LA : GNT_WB;
                    if (pick_la) begin
                        we_d    = la_we_i;
                        addr_d  = la_addr_i;
                        din_d   = la_wdata_i;
                        csb_d   = 1'b0;
                        web_d   = ~la_we_i;
                        wmask_d = la_we_i ? 4'hF : 4'h0;
                        state_d = ISSUE;
                    end else if (wb_in_win) begin
                        we_d    = wbs_we_i;
                        addr_d  = wbs_adr_i[ADDR_W+1:2];
                        din_d   = wbs_dat_i;
                        csb_d   = 1'b0;
                        web_d   = ~wbs_we_i;
                        wmask_d = wbs_we_i ? wbs_sel_i : 4'h0;
                        state_d = ISSUE;
                    end else begin
                        wbs_dat_d = 32'h0;
                        state_d   = DONE;
                    end
                end
            end
            ISSUE: begin
                state_d = we_q ? DONE : CAPTURE;
            end
            CAPTURE: begin
                if (grant_q == GNT_LA) begin
                    la_rdata_d = sram_dout_i;
                end else begin
                    wbs_dat_d = sram_dout_i;
                end
                state_d = DONE;
            end
            DONE: begin
                if (grant_q == GNT_LA) begin
                    la_ack_d = 1'b1;
                end else begin
                    wbs_ack_d = ~abort_d;
                end
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset forces the SRAM deselected immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_LA;
            grant_q      <= GNT_WB;
            we_q         <= 1'b0;
            abort_q      <= 1'b0;
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
            wmask_q      <= 4'h0;
            addr_q       <= '0;
            din_q        <= 32'h0;
            wbs_ack_q    <= 1'b0;
            la_ack_q     <= 1'b0;
            wbs_dat_q    <= 32'h0;
            la_rdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            abort_q      <= abort_d;
            csb_q        <= csb_d;
            web_q        <= web_d;
            wmask_q      <= wmask_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            wbs_ack_q    <= wbs_ack_d;
            la_ack_q     <= la_ack_d;
            wbs_dat_q    <= wbs_dat_d;
            la_rdata_q   <= la_rdata_d;
        end
    end

    assign wbs_ack_o    = wbs_ack_q;
    assign wbs_dat_o    = wbs_dat_q;
    assign la_ack_o     = LA_EN & la_ack_q;
    assign la_rdata_o   = LA_EN ? la_rdata_q : 32'h0;
    assign sram_csb_o   = csb_q;
    assign sram_web_o   = web_q;
    assign sram_wmask_o = wmask_q;
    assign sram_addr_o  = addr_q;
    assign sram_din_o   = din_q;

endmodule
